ds18b20_scan_ctrl: RTL and testbench
====================================

Name: ds18b20_scan_ctrl

Overview:
Scheduler that shares one ds18b20_drive instance between two one-wire sensor buses (inside/outside). It issues periodic conversions on channel 0 then channel 1 and captures each 16-bit result with a timeout. It also rotates the channel shown on seg_drive and blanks a channel that has no valid reading. It sits between the one-wire mux/driver and seg_drive in the top level.

Parameters:
PERIOD, 50_000_000, clocks between automatic scan requests (1 s at 50 MHz)
TIMEOUT, 60_000_000, max clocks in WAIT for drv_done before the channel is declared failed
SETTLE, 500, clocks drv_sel is held stable before the channel-1 start
DWELL, 150_000_000, clocks each channel is displayed before rotating
DP_MASK, 4'b0010, decimal-point pattern driven to seg_drive

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous, active-low reset
force  in  1  level/pulse; requests a scan as soon as IDLE
drv_start  out  1  one-cycle start pulse to ds18b20_drive
drv_sel  out  1  bus select for the one-wire mux: 0 = inside, 1 = outside
drv_busy  in  1  driver transaction in progress
drv_done  in  1  one-cycle pulse; drv_data valid in that cycle
drv_data  in  16  temperature word from the driver
t_ch0  out  16  last good reading, channel 0
t_ch1  out  16  last good reading, channel 1
valid  out  2  bit n = channel n's last attempt succeeded
disp_ch  out  1  channel currently routed to the display
disp_data  out  16  to seg_drive i_data
disp_dp  out  4  to seg_drive i_dp
disp_off  out  4  to seg_drive i_turn_off

Behaviour:
- Reset (async, rst = 0): state = IDLE; pending = 1 (scan immediately after release); all counters = 0.
- Output reset values: drv_start 0, drv_sel 0, t_ch0/t_ch1 0, valid 2'b00, disp_ch 0, disp_data 0, disp_dp DP_MASK, disp_off 4'b1111.
- Reset mid-transaction abandons the scan. No start is reissued until after release.
- Period counter is free-running from 0 to PERIOD-1. At wrap it sets pending. force = 1 in any cycle also sets pending.
- pending is a single flag: requests arriving during a scan merge into one follow-up scan. pending clears on entry to START for channel 0.
- FSM states: IDLE, START, WAIT, SETTLE, DONE.
- IDLE: if pending and !drv_busy, then ch = 0, drv_sel = 0, go to START.
- START: drv_start = 1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT: the timeout counter increments every cycle.
  - drv_done: latch drv_data into t_ch[ch], set valid[ch] = 1, go to DONE.
  - Counter reaches TIMEOUT-1 without drv_done: valid[ch] = 0, t_ch[ch] keeps its old value, go to DONE.
  - drv_done and timeout in the same cycle: drv_done wins.
- DONE:
  - If ch = 0: ch = 1, drv_sel = 1, clear the settle counter, go to SETTLE.
  - If ch = 1: drv_sel = 0, go to IDLE.
- SETTLE: count SETTLE cycles, then go to START if !drv_busy; otherwise hold in SETTLE.
- drv_sel changes only on the DONE/IDLE transitions. It is constant from START through WAIT.
- drv_done outside WAIT is ignored.
- Display:
  - Dwell counter runs 0 to DWELL-1; disp_ch toggles at wrap.
  - disp_data, disp_dp and disp_off are registered: they reflect t_ch/valid/disp_ch one cycle after those change.
  - disp_data = t_ch[disp_ch]; disp_dp = DP_MASK.
  - disp_off = 4'b0000 if valid[disp_ch], else 4'b1111.
- Scan latency without faults: 2 + driver time (ch0) + 1 + SETTLE + 1 + driver time (ch1) + 1 cycles.

Test Plan:
(Bench parameters: PERIOD=100, TIMEOUT=50, SETTLE=4, DWELL=30; driver model returns done after 10 cycles.)
1. Release rst → drv_start pulse with drv_sel=0; done with 16'h0191 → t_ch0=16'h0191, valid=2'b01; drv_sel=1 held 4 cycles; second start; done with 16'h00A0 → t_ch1=16'h00A0, valid=2'b11; drv_start is exactly 1 cycle wide each time.
2. Channel-1 driver never returns done → WAIT exits after 50 cycles; valid[1]=0; t_ch1 retains its prior value; FSM returns to IDLE; next scan starts at the period wrap.
3. drv_done and timeout coincide on cycle 49 of WAIT → the reading is captured and valid[ch]=1.
4. force pulsed 3 times during a scan → exactly one extra scan after IDLE; period wrap during the scan also merges into it (no third scan).
5. Display rotation: valid=2'b01 → disp_ch=0 shows 16'h0191 with disp_off=4'b0000 for 30 cycles; disp_ch=1 then shows disp_off=4'b1111; disp_dp=4'b0010 throughout.
6. rst asserted in WAIT of channel 1 → all outputs at their reset values immediately (async); after release a new scan begins at channel 0.

Source files
------------

// File: rtl/ds18b20_scan_ctrl.sv
// Two-channel DS18B20 scan scheduler: shares one driver between the inside/outside
// one-wire buses, captures readings with a timeout and rotates the displayed channel.
`timescale 1ns/1ps
module ds18b20_scan_ctrl #(
  parameter int         PERIOD  = 50_000_000,
  parameter int         TIMEOUT = 60_000_000,
  parameter int         SETTLE  = 500,
  parameter int         DWELL   = 150_000_000,
  parameter logic [3:0] DP_MASK = 4'b0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        force_req,
  output logic        drv_start,
  output logic        drv_sel,
  input  logic        drv_busy,
  input  logic        drv_done,
  input  logic [15:0] drv_data,
  output logic [15:0] t_ch0,
  output logic [15:0] t_ch1,
  output logic [1:0]  valid,
  output logic        disp_ch,
  output logic [15:0] disp_data,
  output logic [3:0]  disp_dp,
  output logic [3:0]  disp_off
);

  localparam int TMR_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
  localparam int PER_W   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int DWL_W   = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [PER_W-1:0] PER_LAST    = PER_W'(PERIOD - 1);
  localparam logic [TMR_W-1:0] TMO_LAST    = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [DWL_W-1:0] DWL_LAST    = DWL_W'(DWELL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic             ch;
  logic             pending;
  logic [PER_W-1:0] per_cnt;
  logic [TMR_W-1:0] tmr_cnt;
  logic [DWL_W-1:0] dwl_cnt;

  logic scan_go, tmr_clr, cap_ok, cap_fail, to_ch1, to_idle;
  logic per_wrap;

  assign per_wrap = (per_cnt == PER_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d   = state;
    drv_start = 1'b0;
    scan_go   = 1'b0;
    tmr_clr   = 1'b0;
    cap_ok    = 1'b0;
    cap_fail  = 1'b0;
    to_ch1    = 1'b0;
    to_idle   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (pending && !drv_busy) begin
          scan_go = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        drv_start = 1'b1;
        tmr_clr   = 1'b1;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle still counts as a success.
        if (drv_done) begin
          cap_ok  = 1'b1;
          state_d = S_DONE;
        end else if (tmr_cnt == TMO_LAST) begin
          cap_fail = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (!ch) begin
          to_ch1  = 1'b1;
          tmr_clr = 1'b1;
          state_d = S_SETTLE;
        end else begin
          to_idle = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SETTLE: begin
        if (tmr_cnt == SETTLE_LAST && !drv_busy) state_d = S_START;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scan control: request flag, channel/bus select, period and shared timer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b1;
      ch      <= 1'b0;
      drv_sel <= 1'b0;
      per_cnt <= '0;
      tmr_cnt <= '0;
    end else begin
      pending <= per_wrap | force_req | (pending & ~scan_go);
      per_cnt <= per_wrap ? '0 : per_cnt + PER_W'(1);
      if (scan_go) begin
        ch      <= 1'b0;
        drv_sel <= 1'b0;
      end else if (to_ch1) begin
        ch      <= 1'b1;
        drv_sel <= 1'b1;
      end else if (to_idle) begin
        drv_sel <= 1'b0;
      end
      if (tmr_clr)
        tmr_cnt <= '0;
      else if (state == S_WAIT)
        tmr_cnt <= tmr_cnt + TMR_W'(1);
      else if (state == S_SETTLE && tmr_cnt != SETTLE_LAST)
        tmr_cnt <= tmr_cnt + TMR_W'(1);
    end
  end

  // Result capture: a failed attempt clears the valid flag but keeps the old reading.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_ch0 <= '0;
      t_ch1 <= '0;
      valid <= 2'b00;
    end else if (cap_ok) begin
      if (ch) t_ch1 <= drv_data;
      else    t_ch0 <= drv_data;
      valid[ch] <= 1'b1;
    end else if (cap_fail) begin
      valid[ch] <= 1'b0;
    end
  end

  // Display stage: registered one cycle behind the readings and selected channel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dwl_cnt   <= '0;
      disp_ch   <= 1'b0;
      disp_data <= '0;
      disp_dp   <= DP_MASK;
      disp_off  <= 4'b1111;
    end else begin
      if (dwl_cnt == DWL_LAST) begin
        dwl_cnt <= '0;
        disp_ch <= ~disp_ch;
      end else begin
        dwl_cnt <= dwl_cnt + DWL_W'(1);
      end
      disp_data <= disp_ch ? t_ch1 : t_ch0;
      disp_dp   <= DP_MASK;
      disp_off  <= valid[disp_ch] ? 4'b0000 : 4'b1111;
    end
  end

endmodule

// File: tb/tb_ds18b20_scan_ctrl.sv
// Scoreboard bench for ds18b20_scan_ctrl: a behavioural driver model predicts each
// channel result; a monitor pops predictions whenever the DUT finishes a channel.
`timescale 1ns/1ps
module tb_ds18b20_scan_ctrl;
  localparam int         PERIOD  = 100;
  localparam int         TIMEOUT = 50;
  localparam int         SETTLE  = 4;
  localparam int         DWELL   = 30;
  localparam logic [3:0] DP      = 4'b0010;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        force_req = 1'b0;
  logic        drv_busy = 1'b0;
  logic        drv_done = 1'b0;
  logic [15:0] drv_data = 16'h0000;
  logic        drv_start, drv_sel, disp_ch;
  logic [15:0] t_ch0, t_ch1, disp_data;
  logic [1:0]  valid;
  logic [3:0]  disp_dp, disp_off;

  ds18b20_scan_ctrl #(
    .PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .SETTLE(SETTLE), .DWELL(DWELL), .DP_MASK(DP)
  ) dut (
    .clk(clk), .rst(rst), .force_req(force_req),
    .drv_start(drv_start), .drv_sel(drv_sel), .drv_busy(drv_busy),
    .drv_done(drv_done), .drv_data(drv_data),
    .t_ch0(t_ch0), .t_ch1(t_ch1), .valid(valid),
    .disp_ch(disp_ch), .disp_data(disp_data), .disp_dp(disp_dp), .disp_off(disp_off)
  );

  always #5 clk = ~clk;

  // n = number of rising edges since reset release
  int n;
  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (n=%0d)", name, act, req, n);
    end
  endtask

  typedef struct {
    logic [15:0] t0;
    logic [15:0] t1;
    logic [1:0]  v;
    int          dur;
    bit          ch;
  } exp_t;

  exp_t        exp_q[$];
  int          start0_q[$];
  logic [15:0] mt[2];
  bit          mv[2];

  // driver behaviour knobs: delay 0 means random in 1..cfg_dmax
  bit          cfg_fix[2];
  logic [15:0] cfg_dat[2];
  int          cfg_dly[2];
  int          cfg_dmax;

  function automatic bit has_start(input int v);
    foreach (start0_q[i]) if (start0_q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int count_start(input int lo, input int hi);
    int c = 0;
    foreach (start0_q[i]) if (start0_q[i] >= lo && start0_q[i] <= hi) c++;
    return c;
  endfunction

  task automatic wait_n(input int k);
    while (n < k) @(negedge clk);
  endtask

  task automatic pulse_force();
    force_req = 1'b1;
    @(negedge clk);
    force_req = 1'b0;
  endtask

  task automatic chk_reset();
    chk("rst_drv_start", 32'(drv_start), 32'd0);
    chk("rst_drv_sel",   32'(drv_sel),   32'd0);
    chk("rst_t_ch0",     32'(t_ch0),     32'd0);
    chk("rst_t_ch1",     32'(t_ch1),     32'd0);
    chk("rst_valid",     32'(valid),     32'd0);
    chk("rst_disp_ch",   32'(disp_ch),   32'd0);
    chk("rst_disp_data", 32'(disp_data), 32'd0);
    chk("rst_disp_dp",   32'(disp_dp),   32'(DP));
    chk("rst_disp_off",  32'(disp_off),  32'hF);
  endtask

  // Driver model: a channel succeeds iff its response delay fits in the timeout window.
  initial begin
    bit          c, ok, ab;
    int          dl, k;
    logic [15:0] d;
    forever begin
      @(posedge clk); #1;
      if (rst && drv_start) begin
        c  = drv_sel;
        dl = (cfg_dly[c] != 0) ? cfg_dly[c] : int'($urandom_range(cfg_dmax, 1));
        d  = cfg_fix[c] ? cfg_dat[c] : 16'($urandom);
        ok = (dl <= TIMEOUT);
        k  = ok ? dl : TIMEOUT + 1;
        ab = 1'b0;
        drv_busy = 1'b1;
        for (int i = 0; i < k; i++) begin
          @(posedge clk); #1;
          if (!rst) begin
            ab = 1'b1;
            break;
          end
        end
        if (!ab) begin
          // a late response lands outside the wait window and must be ignored
          drv_data = ok ? d : ~d;
          drv_done = 1'b1;
          if (ok) begin
            mt[c] = d;
            mv[c] = 1'b1;
          end else begin
            mv[c] = 1'b0;
          end
          exp_q.push_back('{t0: mt[0], t1: mt[1], v: {mv[1], mv[0]},
                            dur: (ok ? dl : TIMEOUT) + 2, ch: c});
          @(posedge clk); #1;
        end
        drv_done = 1'b0;
        drv_busy = 1'b0;
      end
    end
  end

  // Monitor: checks each start pulse and scores each completed channel.
  int pops = 0;
  initial begin
    bit   prev_sel = 1'b0;
    bit   exp_ch = 1'b0;
    bit   chk_lo = 1'b0;
    int   rise_n = 0;
    int   start_n = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_sel = 1'b0;
        exp_ch   = 1'b0;
        chk_lo   = 1'b0;
      end else begin
        if (chk_lo) begin
          chk("start_width", 32'(drv_start), 32'd0);
          chk_lo = 1'b0;
        end
        if (drv_start) begin
          chk("start_sel", 32'(drv_sel), 32'(exp_ch));
          if (drv_sel) chk("settle_len", 32'(n - rise_n), 32'(SETTLE));
          else         start0_q.push_back(n);
          start_n = n;
          exp_ch  = ~exp_ch;
          chk_lo  = 1'b1;
        end
        if (drv_sel != prev_sel) begin
          if (drv_sel) rise_n = n;
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            pops++;
            chk("res_t_ch0",   32'(t_ch0),       32'(e.t0));
            chk("res_t_ch1",   32'(t_ch1),       32'(e.t1));
            chk("res_valid",   32'(valid),       32'(e.v));
            chk("res_latency", 32'(n - start_n), 32'(e.dur));
            chk("res_sel",     32'(drv_sel),     32'(!e.ch));
          end
        end
        prev_sel = drv_sel;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  dp, dn;
    bit  found;
    cfg_fix  = '{1'b1, 1'b1};
    cfg_dat  = '{16'h0191, 16'h00A0};
    cfg_dly  = '{10, 10};
    cfg_dmax = 20;
    mt = '{16'h0000, 16'h0000};
    mv = '{1'b0, 1'b0};
    @(negedge clk);
    chk_reset();
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;

    // basic two-channel scan right after reset
    wait_n(60);
    chk("t1_t_ch0",  32'(t_ch0), 32'h0191);
    chk("t1_t_ch1",  32'(t_ch1), 32'h00A0);
    chk("t1_valid",  32'(valid), 32'd3);
    chk("t1_start0", 32'(has_start(1)), 32'd1);

    // channel 1 never answers
    cfg_fix[0] = 1'b0; cfg_dly[0] = 0; cfg_dly[1] = 60;
    wait_n(190);
    chk("t2_t_ch1_kept", 32'(t_ch1),    32'h00A0);
    chk("t2_valid1",     32'(valid[1]), 32'd0);

    // response on the very last wait cycle of channel 0
    cfg_dly[0] = 50; cfg_dly[1] = 0; cfg_fix[1] = 1'b0;
    wait_n(205);
    chk("t2_wrap_start", 32'(has_start(201)), 32'd1);
    wait_n(290);
    chk("t3_valid",  32'(valid), 32'd3);
    chk("t3_t_ch0",  32'(t_ch0), 32'(mt[0]));
    cfg_dly = '{0, 0};

    // request merging: force while idle, then forces and a period wrap mid-scan
    wait_n(355); cfg_dly = '{20, 20};
    wait_n(360); pulse_force();
    wait_n(370); pulse_force();
    wait_n(380); pulse_force();
    wait_n(395); pulse_force();
    cfg_dly = '{0, 0};

    // display rotation with channel 1 failing
    wait_n(465);
    cfg_fix[0] = 1'b1; cfg_dat[0] = 16'h0191; cfg_dly[0] = 10; cfg_dly[1] = 60;
    wait_n(499);
    chk("t4_merged_scans", 32'(count_start(355, 499)), 32'd2);
    wait_n(505);
    chk("t4_next_wrap", 32'(has_start(501)), 32'd1);
    wait_n(575);
    chk("t5_valid", 32'(valid), 32'd1);
    while (n <= 690) begin
      dn = (n / DWELL) % 2;
      dp = ((n - 1) / DWELL) % 2;
      chk("disp_ch",   32'(disp_ch),   32'(dn));
      chk("disp_data", 32'(disp_data), 32'(mt[dp]));
      chk("disp_off",  32'(disp_off),  mv[dp] ? 32'h0 : 32'hF);
      chk("disp_dp",   32'(disp_dp),   32'(DP));
      @(negedge clk);
    end

    // reset while channel 1 is waiting
    wait_n(695);
    cfg_fix[0] = 1'b0; cfg_dly[0] = 10; cfg_dly[1] = 60;
    found = 1'b0;
    while (n < 800 && !found) begin
      if (drv_start && drv_sel) found = 1'b1;
      else @(negedge clk);
    end
    chk("t6_ch1_start_seen", 32'(found), 32'd1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    mt = '{16'h0000, 16'h0000};
    mv = '{1'b0, 1'b0};
    start0_q.delete();
    exp_q.delete();
    #1 chk_reset();
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // randomized scans including timeouts
    cfg_fix = '{1'b0, 1'b0}; cfg_dly = '{0, 0}; cfg_dmax = 60;
    wait_n(5);
    chk("t6_restart_ch0", 32'(has_start(1)), 32'd1);
    wait_n(1000);
    chk("final_pops",    32'(pops >= 25),         32'd1);
    chk("final_backlog", 32'(exp_q.size() <= 1),  32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
